// File: rtl/screens_timing_gen.sv
// Raster timing generator with test-pattern mux over upstream pixel colour.
// Display latency PIPE_LAT+1 clocks; free-running, no backpressure.
module screens_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int PIPE_LAT = 2,
  parameter int GRID     = 32
) (
  input  logic               clk_25,
  input  logic               resetN,
  input  logic [1:0]         pattern_sel,
  input  logic [COLOR_W-1:0] Red_level,
  input  logic [COLOR_W-1:0] Green_level,
  input  logic [COLOR_W-1:0] Blue_level,
  output logic [10:0]        pxl_x,
  output logic [10:0]        pxl_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_cnt,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue,
  output logic               h_sync,
  output logic               v_sync,
  output logic               disp_ena
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);
  localparam logic [10:0] G_MASK = 11'(GRID - 1);

  localparam logic [COLOR_W-1:0] ONES = '1;
  localparam logic [COLOR_W-1:0] GREY = ONES ^ (ONES >> 1);

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  pat;
  } stage_t;

  logic        run;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [1:0]  pat_q;
  logic [1:0]  pat_cur;
  stage_t      stage_in;
  stage_t      dly;

  // run holds the counters at (0,0) for one cycle after release so the
  // first issued coordinate carries frame_start.
  assign line_start  = run && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);
  assign pxl_x       = h_cnt;
  assign pxl_y       = v_cnt;
  assign pat_cur     = frame_start ? pattern_sel : pat_q;

  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      run       <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      pat_q     <= '0;
    end else begin
      run   <= 1'b1;
      pat_q <= pat_cur;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt     <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            v_cnt <= v_cnt + 11'd1;
          end
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  always_comb begin
    stage_in = '0;
    if (run) begin
      stage_in.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      stage_in.hs  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      stage_in.vs  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      stage_in.x   = h_cnt;
      stage_in.y   = v_cnt;
      stage_in.pat = pat_cur;
    end
  end

  // Delay line matches the upstream drawing latency; pattern rides along.
  if (PIPE_LAT == 0) begin : g_no_dly
    assign dly = stage_in;
  end else begin : g_dly
    stage_t pipe_q [PIPE_LAT];
    always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= stage_in;
        for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign dly = pipe_q[PIPE_LAT-1];
  end

  logic [2:0]         bar;
  logic               grid_on;
  logic [COLOR_W-1:0] r_mux;
  logic [COLOR_W-1:0] g_mux;
  logic [COLOR_W-1:0] b_mux;

  always_comb begin
    bar     = 3'(dly.x / BAR_W);
    grid_on = ((dly.x & G_MASK) == '0) || ((dly.y & G_MASK) == '0);
    r_mux   = '0;
    g_mux   = '0;
    b_mux   = '0;
    case (dly.pat)
      2'd0: begin
        r_mux = Red_level;
        g_mux = Green_level;
        b_mux = Blue_level;
      end
      2'd1: begin
        // Bar index bits map straight onto the white..black RGB sequence.
        r_mux = bar[1] ? '0 : ONES;
        g_mux = bar[2] ? '0 : ONES;
        b_mux = bar[0] ? '0 : ONES;
      end
      2'd2: begin
        r_mux = grid_on ? ONES : '0;
        g_mux = grid_on ? ONES : '0;
        b_mux = grid_on ? ONES : '0;
      end
      default: begin
        r_mux = GREY;
        g_mux = GREY;
        b_mux = GREY;
      end
    endcase
  end

  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      Red      <= '0;
      Green    <= '0;
      Blue     <= '0;
      disp_ena <= 1'b0;
      h_sync   <= ~SYNC_POL;
      v_sync   <= ~SYNC_POL;
    end else begin
      Red      <= dly.act ? r_mux : '0;
      Green    <= dly.act ? g_mux : '0;
      Blue     <= dly.act ? b_mux : '0;
      disp_ena <= dly.act;
      h_sync   <= dly.hs ? SYNC_POL : ~SYNC_POL;
      v_sync   <= dly.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_screens_timing_gen.sv
// Directed bench for screens_timing_gen on a 16x8 total / 8x4 visible raster.
module tb_screens_timing_gen;

  logic        clk_25 = 1'b0;
  logic        resetN;
  logic [1:0]  pattern_sel;
  logic [3:0]  Red_level, Green_level, Blue_level;
  logic [10:0] pxl_x, pxl_y;
  logic        line_start, frame_start;
  logic [15:0] frame_cnt;
  logic [3:0]  Red, Green, Blue;
  logic        h_sync, v_sync, disp_ena;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected bar colours as {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
  logic [2:0] bar_rgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  always #5 clk_25 = ~clk_25;

  screens_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(1'b0), .COLOR_W(4), .PIPE_LAT(2), .GRID(4)
  ) dut (
    .clk_25(clk_25), .resetN(resetN), .pattern_sel(pattern_sel),
    .Red_level(Red_level), .Green_level(Green_level), .Blue_level(Blue_level),
    .pxl_x(pxl_x), .pxl_y(pxl_y), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .Red(Red), .Green(Green), .Blue(Blue),
    .h_sync(h_sync), .v_sync(v_sync), .disp_ena(disp_ena)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},      32'(pxl_x),       32'd0);
    check({tag, "_y"},      32'(pxl_y),       32'd0);
    check({tag, "_ls"},     32'(line_start),  32'd0);
    check({tag, "_fs"},     32'(frame_start), 32'd0);
    check({tag, "_fcnt"},   32'(frame_cnt),   32'd0);
    check({tag, "_rgb"},    32'({Red, Green, Blue}), 32'd0);
    check({tag, "_ena"},    32'(disp_ena),    32'd0);
    check({tag, "_hsync"},  32'(h_sync),      32'd1);
    check({tag, "_vsync"},  32'(v_sync),      32'd1);
  endtask

  // Pattern latched at the start of each frame, given the pattern_sel schedule below.
  function automatic logic [1:0] frame_pat(input int f);
    case (f)
      1:       return 2'd1;
      2:       return 2'd2;
      3:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    int k, ex, ey;
    logic [1:0] p;
    logic act, ehs, evs;
    logic [3:0] er, eg, eb;

    resetN      = 1'b0;
    pattern_sel = 2'd0;
    Red_level   = '0;
    Green_level = '0;
    Blue_level  = '0;
    repeat (3) tick();
    cyc = -1;
    check_reset_outputs("rst");

    @(negedge clk_25);
    resetN = 1'b1;
    #1;
    check("prerun_ls", 32'(line_start),  32'd0);
    check("prerun_fs", 32'(frame_start), 32'd0);
    tick();

    for (int c = 0; c < 677; c++) begin
      cyc = c;
      if (c >= 2) begin
        Red_level   = 4'((c - 2) % 16);
        Green_level = 4'(((c - 2) / 16) % 8);
      end else begin
        Red_level   = '0;
        Green_level = '0;
      end
      Blue_level = 4'hA;
      if (c == 32)  pattern_sel = 2'd1;
      if (c == 200) pattern_sel = 2'd2;
      if (c == 300) pattern_sel = 2'd3;
      if (c == 400) pattern_sel = 2'd0;

      check("pxl_x",       32'(pxl_x),       32'(c % 16));
      check("pxl_y",       32'(pxl_y),       32'((c / 16) % 8));
      check("line_start",  32'(line_start),  32'(c % 16 == 0));
      check("frame_start", 32'(frame_start), 32'(c % 128 == 0));
      check("frame_cnt",   32'(frame_cnt),   32'(c / 128));

      k = c - 3;
      ex = 0; ey = 0; p = 2'd0;
      act = 1'b0; ehs = 1'b1; evs = 1'b1;
      if (k >= 0) begin
        ex  = k % 16;
        ey  = (k / 16) % 8;
        p   = frame_pat(k / 128);
        act = (ex < 8) && (ey < 4);
        ehs = !(ex >= 10 && ex <= 12);
        evs = (ey != 5);
      end
      er = '0; eg = '0; eb = '0;
      if (act) begin
        case (p)
          2'd0: begin er = 4'(ex); eg = 4'(ey); eb = 4'hA; end
          2'd1: begin
            er = {4{bar_rgb[ex][2]}};
            eg = {4{bar_rgb[ex][1]}};
            eb = {4{bar_rgb[ex][0]}};
          end
          2'd2: begin
            if (ex % 4 == 0 || ey % 4 == 0) begin er = 4'hF; eg = 4'hF; eb = 4'hF; end
          end
          default: begin er = 4'h8; eg = 4'h8; eb = 4'h8; end
        endcase
      end
      check("disp_ena", 32'(disp_ena), 32'(act));
      check("h_sync",   32'(h_sync),   32'(ehs));
      check("v_sync",   32'(v_sync),   32'(evs));
      check("Red",      32'(Red),      32'(er));
      check("Green",    32'(Green),    32'(eg));
      check("Blue",     32'(Blue),     32'(eb));
      tick();
    end

    cyc = 677;
    check("pre_rst_x", 32'(pxl_x), 32'd5);
    check("pre_rst_y", 32'(pxl_y), 32'd2);
    resetN = 1'b0;
    #1;
    check_reset_outputs("midrst");

    @(negedge clk_25);
    resetN = 1'b1;
    tick();
    cyc = 0;
    check("rel_x",    32'(pxl_x),       32'd0);
    check("rel_y",    32'(pxl_y),       32'd0);
    check("rel_fs",   32'(frame_start), 32'd1);
    check("rel_ls",   32'(line_start),  32'd1);
    check("rel_fcnt", 32'(frame_cnt),   32'd0);
    check("rel_ena",  32'(disp_ena),    32'd0);
    tick();
    cyc = 1;
    check("rel1_x",  32'(pxl_x),       32'd1);
    check("rel1_fs", 32'(frame_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screens_timing_gen.md
SCREENS_TIMING_GEN -- requirements
Module: screens_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-006 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-007 SHALL have parameter PIPE_LAT, default 2, range 0..8, upstream drawing latency in clocks.
REQ-008 SHALL have parameter GRID, default 32, grid pitch; a power of 2.
REQ-009 clk_25  input  1  pixel clock; all state changes on its rising edge.
REQ-010 resetN  input  1  asynchronous, active-low reset.
REQ-011 pattern_sel  input  2  output source: 0 pass-through, 1 colour bars, 2 grid, 3 mid-grey.
REQ-012 Red_level, Green_level, Blue_level  input  COLOR_W each  upstream pixel colour.
REQ-013 pxl_x, pxl_y  output  11 each  coordinate currently issued to upstream.
REQ-014 line_start, frame_start  output  1 each  single-cycle pulses aligned with pxl_x/pxl_y.
REQ-015 frame_cnt  output  16  completed-frame counter.
REQ-016 Red, Green, Blue  output  COLOR_W each; h_sync, v_sync, disp_ena  output  1 each  registered display-side signals.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H_* widths) and wrap to 0; v_cnt SHALL increment when h_cnt wraps and SHALL wrap to 0 after V_TOTAL-1.
REQ-018 pxl_x = h_cnt and pxl_y = v_cnt SHALL hold in the same cycle, zero-extended to 11 bits.
REQ-019 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-020 Raw hsync SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync likewise on v_cnt with the V_* widths; asserted level = SYNC_POL.
REQ-021 line_start SHALL be 1 exactly when h_cnt==0; frame_start SHALL be 1 exactly when h_cnt==0 and v_cnt==0.
REQ-022 frame_cnt SHALL increment, modulo 2^16, on the cycle counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-023 active, raw hsync, raw vsync, h_cnt and v_cnt SHALL pass through a PIPE_LAT-stage delay line; Red_level/Green_level/Blue_level at cycle t+PIPE_LAT belong to the coordinate issued at cycle t.
REQ-024 The colour mux SHALL operate on delayed coordinates and inputs; its result, delayed active and delayed syncs SHALL be registered once more, so total display latency = PIPE_LAT+1 clocks.
REQ-025 Red/Green/Blue SHALL be 0 whenever delayed active = 0, regardless of pattern.
REQ-026 pattern 1 SHALL produce 8 bars of width H_ACTIVE/8 (H_ACTIVE divisible by 8): white, yellow, cyan, green, magenta, red, blue, black, left to right; each component all-ones or zero.
REQ-027 pattern 2 SHALL produce all-ones on all channels where x mod GRID == 0 or y mod GRID == 0, else 0.
REQ-028 pattern 3 SHALL output only the channel MSB set, all channels.
REQ-029 pattern_sel SHALL be latched only when frame_start = 1; a mid-frame change SHALL take effect at the next frame, never mid-line.
REQ-030 The latched pattern SHALL travel with the delay line so the frame boundary switches cleanly at the display side.

Reset
REQ-031 With resetN = 0: h_cnt, v_cnt, frame_cnt = 0; latched pattern = 0; all delay stages cleared to active = 0 and syncs inactive.
REQ-032 During reset: Red/Green/Blue = 0, disp_ena = 0, h_sync = v_sync = !SYNC_POL, line_start = frame_start = 0.
REQ-033 First cycle after release SHALL issue (0,0) with frame_start = 1; reset asserted mid-frame SHALL abort immediately with no partial-frame frame_cnt increment.

Verification (H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, PIPE_LAT=2, GRID=4)
REQ-034 Free run 2 frames -> line_start every 16 clocks; frame_start every 128 clocks; frame_cnt 0 -> 1 -> 2.
REQ-035 h_cnt 10..12 issued -> h_sync low on the 3 cycles 3 clocks later; v_sync low for line 5 only, delayed 3 clocks.
REQ-036 pattern 0, Red_level = pxl_x(t-2) -> Red at t+1 equals x; blanked (0) for x 8..15 and for lines 4..7.
REQ-037 pattern 1 -> per-pixel colour order white, yellow, cyan, green, magenta, red, blue, black across x 0..7; pattern 2 -> white at x 0, 4 and on line 0 only.
REQ-038 pattern_sel 0 -> 1 switched at line 2 -> current frame stays pass-through; next frame shows bars from its first visible pixel.
REQ-039 resetN pulsed low at (5,2) -> all outputs at reset values asynchronously; on release, (0,0) with frame_start = 1 and frame_cnt = 0.
